// File: rtl/pet_event_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pet_event_scheduler_pkg                                             |
// | Stat codes, scheduler FSM encoding and update record for the pet.   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package pet_event_scheduler_pkg;

  typedef enum logic [1:0] {
    STAT_ENERGY = 2'd0,
    STAT_HUNGER = 2'd1,
    STAT_ENTERT = 2'd2
  } stat_e;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  // Pending-flag slots: 0..2 are the timer sources (same as stat code), 3 is feed.
  localparam logic [1:0] SRC_FEED = 2'd3;

  typedef struct packed {
    stat_e stat;
    logic  inc;
  } upd_t;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pet_event_scheduler_ms_period_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ms_period_timer                                                     |
// | Counts ms ticks and pulses wrap_o on the tick that completes a period.|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module ms_period_timer #(
  parameter int PERIOD_MS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic en_i,
  output logic wrap_o
);

  localparam int         CW   = $clog2(PERIOD_MS + 1);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_MS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_o = 1'b0;
    if (tick_i && en_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        wrap_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/pet_event_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pet_event_scheduler                                                 |
// | Turns periodic timers and feed presses into one-at-a-time stat updates.|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module pet_event_scheduler
  import pet_event_scheduler_pkg::*;
#(
  parameter int COUNT_MAX = 50000,
  parameter int ENER_MS   = 40000,
  parameter int FEED_MS   = 10000,
  parameter int ENTERT_MS = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       feed_req,
  input  logic       sleeping,
  input  logic       playing,
  input  logic       dead,
  output logic       upd_valid,
  input  logic       upd_ready,
  output logic [1:0] upd_stat,
  output logic       upd_inc,
  output logic [7:0] drop_cnt
);

  localparam int PW = $clog2(COUNT_MAX + 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          ms_tick;
  logic [2:0]    tmr_fire;
  logic          feed_q;
  logic          feed_edge;
  logic [3:0]    pend_q, pend_d;
  logic [3:0]    set_vec, clr_vec, drop_vec;
  logic [2:0]    n_drop;
  logic [8:0]    drop_sum;
  logic [7:0]    drop_q, drop_d;
  logic [0:0]    state_q, state_d;
  logic          accept;
  logic          load;
  logic [1:0]    rr_q, src_q;
  logic [1:0]    cand0, cand1, cand2;
  logic [1:0]    arb_src;
  upd_t          arb_upd, gnt_q;

  always_comb begin
    ms_tick = (pre_q == PW'(COUNT_MAX - 1));
    pre_d   = ms_tick ? '0 : pre_q + 1'b1;
  end

  // Slot order matches the stat codes: energy, hunger, entertainment.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_timer
      ms_period_timer #(
        .PERIOD_MS((gi == 0) ? ENER_MS : (gi == 1) ? FEED_MS : ENTERT_MS)
      ) u_tmr (
        .clk    (clk),
        .rst    (rst),
        .tick_i (ms_tick),
        .en_i   (~dead),
        .wrap_o (tmr_fire[gi])
      );
    end
  endgenerate

  always_comb begin
    feed_edge = feed_req & ~feed_q & ~dead;
    set_vec   = {feed_edge, tmr_fire};
    accept    = (state_q == ST_ISSUE) && upd_ready && !dead;
    clr_vec   = accept ? (4'b0001 << src_q) : 4'b0000;
    drop_vec  = set_vec & pend_q & ~clr_vec;
    pend_d    = dead ? 4'b0000 : ((pend_q & ~clr_vec) | set_vec);
    n_drop    = 3'(drop_vec[0]) + 3'(drop_vec[1]) + 3'(drop_vec[2]) + 3'(drop_vec[3]);
    drop_sum  = {1'b0, drop_q} + {6'd0, n_drop};
    drop_d    = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Feed wins outright; timers rotate starting after the last timer granted.
  always_comb begin
    cand0   = rr_q;
    cand1   = rr_next(rr_q);
    cand2   = rr_next(cand1);
    arb_src = SRC_FEED;
    arb_upd = '{stat: STAT_HUNGER, inc: 1'b1};
    if (!pend_q[SRC_FEED]) begin
      if (pend_q[cand0])      arb_src = cand0;
      else if (pend_q[cand1]) arb_src = cand1;
      else                    arb_src = cand2;
      arb_upd.stat = stat_e'(arb_src);
      case (arb_src)
        2'd0:    arb_upd.inc = sleeping;
        2'd2:    arb_upd.inc = playing;
        default: arb_upd.inc = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!dead && (|pend_q))  state_d = ST_ISSUE;
      ST_ISSUE: if (dead || upd_ready)   state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    upd_valid = (state_q == ST_ISSUE);
    upd_stat  = gnt_q.stat;
    upd_inc   = gnt_q.inc;
    drop_cnt  = drop_q;
  end

  assign load = (state_q == ST_IDLE) && (state_d == ST_ISSUE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q  <= '0;
      feed_q <= 1'b0;
      pend_q <= 4'b0000;
      drop_q <= 8'd0;
      rr_q   <= 2'd0;
      src_q  <= 2'd0;
      gnt_q  <= '0;
    end else begin
      pre_q  <= pre_d;
      feed_q <= feed_req;
      pend_q <= pend_d;
      drop_q <= drop_d;
      if (load) begin
        src_q <= arb_src;
        gnt_q <= arb_upd;
        if (arb_src != SRC_FEED) rr_q <= rr_next(arb_src);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pet_event_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pet_event_scheduler                                              |
// | Directed bench with 4-cycle ms, periods energy 3, hunger 2, entert 5.|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_pet_event_scheduler;

  localparam logic [1:0] E = 2'd0;
  localparam logic [1:0] H = 2'd1;
  localparam logic [1:0] T = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       feed_req = 1'b0;
  logic       sleeping = 1'b0;
  logic       playing = 1'b0;
  logic       dead = 1'b0;
  logic       upd_ready = 1'b1;
  logic       upd_valid;
  logic [1:0] upd_stat;
  logic       upd_inc;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  pet_event_scheduler #(
    .COUNT_MAX(4),
    .ENER_MS  (3),
    .FEED_MS  (2),
    .ENTERT_MS(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .feed_req (feed_req),
    .sleeping (sleeping),
    .playing  (playing),
    .dead     (dead),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_stat (upd_stat),
    .upd_inc  (upd_inc),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycle n = n-th negedge after reset release (prescaler reads n mod 4).
  task automatic goto(input int n);
    while ((cyc - t0) < n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(upd_valid), 0);
    chk("rst_stat",  32'(upd_stat),  0);
    chk("rst_inc",   32'(upd_inc),   0);
    chk("rst_drop",  32'(drop_cnt),  0);
    rst = 1'b1;
    t0  = cyc;
  endtask

  task automatic chk_upd(input string tag, input logic [1:0] est, input logic einc, input int eat);
    bit         ok;
    logic [1:0] st;
    logic       inc;
    int         at;
    ok  = 1'b0;
    st  = 2'bxx;
    inc = 1'bx;
    at  = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (upd_valid && upd_ready) begin
        ok  = 1'b1;
        st  = upd_stat;
        inc = upd_inc;
        at  = cyc - t0;
        break;
      end
    end
    checks++;
    assert (ok && st === est && inc === einc && at == eat) else begin
      errors++;
      $error("FAIL %s: got ok=%0b stat=%0d inc=%0b cycle=%0d, expected stat=%0d inc=%0b cycle=%0d",
             tag, ok, st, inc, at, est, einc, eat);
    end
  endtask

  initial begin
    // Idle pet, always ready: hunger at ms 2 and 4, energy at 3, entertainment at 5.
    do_reset(3);
    chk_upd("t1_hunger_ms2", H, 1'b0, 9);
    chk_upd("t1_energy_ms3", E, 1'b0, 13);
    chk_upd("t1_hunger_ms4", H, 1'b0, 17);
    chk_upd("t1_entert_ms5", T, 1'b0, 21);
    goto(22);
    chk("t1_valid_pulse", 32'(upd_valid), 0);
    chk("t1_drop", 32'(drop_cnt), 0);

    // Sleeping and playing flip energy/entertainment to increments.
    sleeping = 1'b1;
    playing  = 1'b1;
    do_reset(2);
    chk_upd("t2_hunger", H, 1'b0, 9);
    chk_upd("t2_energy", E, 1'b1, 13);
    chk_upd("t2_hunger2", H, 1'b0, 17);
    chk_upd("t2_entert", T, 1'b1, 21);
    sleeping = 1'b0;
    playing  = 1'b0;

    // Feed press lands with the first hunger event and is held 10 cycles.
    do_reset(2);
    goto(7);
    feed_req = 1'b1;
    chk_upd("t3_feed", H, 1'b1, 9);
    chk_upd("t3_hunger", H, 1'b0, 11);
    chk_upd("t3_energy", E, 1'b0, 13);
    goto(17);
    chk("t3_hunger2", 32'({upd_valid, upd_stat, upd_inc}), 32'(4'b1010));
    feed_req = 1'b0;
    chk_upd("t3_entert", T, 1'b0, 21);
    chk("t3_drop", 32'(drop_cnt), 0);

    // Back-pressure for 20 ms: held offer, drops counted, round-robin drain.
    upd_ready = 1'b0;
    do_reset(2);
    goto(8);
    chk("t4_latency", 32'(upd_valid), 0);
    for (int c = 9; c <= 80; c++) begin
      goto(c);
      chk("t4_hold", 32'({upd_valid, upd_stat, upd_inc}), 32'(4'b1010));
    end
    chk("t4_drop20", 32'(drop_cnt), 17);
    upd_ready = 1'b1;
    chk_upd("t4_drain_entert", T, 1'b0, 82);
    chk_upd("t4_drain_energy", E, 1'b0, 84);
    chk_upd("t4_next_hunger", H, 1'b0, 89);
    chk("t4_drop_final", 32'(drop_cnt), 18);

    // Death mid-offer: offer withdrawn, counters frozen, feed ignored.
    upd_ready = 1'b0;
    do_reset(2);
    goto(9);
    chk("t5_pre_valid", 32'({upd_valid, upd_stat}), 32'(3'b101));
    dead = 1'b1;
    goto(10);
    chk("t5_dead_valid", 32'(upd_valid), 0);
    goto(15);
    feed_req = 1'b1;
    goto(20);
    feed_req = 1'b0;
    chk("t5_dead_valid2", 32'(upd_valid), 0);
    goto(30);
    chk("t5_dead_valid3", 32'(upd_valid), 0);
    chk("t5_drop", 32'(drop_cnt), 0);
    dead = 1'b0;
    upd_ready = 1'b1;
    chk_upd("t5_resume_energy", E, 1'b0, 33);
    chk_upd("t5_resume_hunger", H, 1'b0, 37);
    chk_upd("t5_resume_entert", T, 1'b0, 41);

    // One-cycle reset while an update is being offered.
    upd_ready = 1'b0;
    do_reset(2);
    goto(9);
    chk("t6_pre_valid", 32'({upd_valid, upd_stat}), 32'(3'b101));
    do_reset(1);
    upd_ready = 1'b1;
    chk_upd("t6_first_hunger", H, 1'b0, 9);
    chk_upd("t6_first_energy", E, 1'b0, 13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pet_event_scheduler.md
PET_EVENT_SCHEDULER -- requirements
Module: pet_event_scheduler

Interface
REQ-001 SHALL have parameter COUNT_MAX, default 50000: clk cycles per ms tick.
REQ-002 SHALL have parameter ENER_MS, default 40000: ms between energy events.
REQ-003 SHALL have parameter FEED_MS, default 10000: ms between hunger events.
REQ-004 SHALL have parameter ENTERT_MS, default 20000: ms between entertainment events.
REQ-005 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-007 SHALL have port feed_req  input  1  feed button; level, rising edge detected internally.
REQ-008 SHALL have port sleeping  input  1  pet FSM is in SLEEP.
REQ-009 SHALL have port playing  input  1  pet FSM is in PLAYING.
REQ-010 SHALL have port dead  input  1  pet FSM is in DEATH.
REQ-011 SHALL have port upd_valid  output  1  stat update offered.
REQ-012 SHALL have port upd_ready  input  1  stat datapath accepts the update.
REQ-013 SHALL have port upd_stat  output  2  0 energy, 1 hunger, 2 entertainment.
REQ-014 SHALL have port upd_inc  output  1  1 = +1, 0 = -1.
REQ-015 SHALL have port drop_cnt  output  8  saturating count of lost events.

Function
REQ-016 SHALL generate ms_tick, a one-cycle pulse every COUNT_MAX clk cycles, from one shared prescaler.
REQ-017 SHALL keep three independent ms counters; each counter reaching its period-1 on ms_tick SHALL wrap to 0 and set that source's pending flag.
REQ-018 SHALL set the feed pending flag on a 0->1 transition of feed_req; a held level SHALL produce one event only.
REQ-019 SHALL map each source to a direction: energy inc if sleeping else dec; hunger dec; entertainment inc if playing else dec; feed inc on stat 1. Direction SHALL be sampled at grant.
REQ-020 SHALL use FSM IDLE/ISSUE: IDLE with any pending -> ISSUE next cycle with grant latched; ISSUE with upd_ready -> IDLE, granted pending cleared.
REQ-021 SHALL arbitrate feed first, then timer sources round-robin from the source after the last timer grant; the order after reset SHALL be energy, hunger, entertainment.
REQ-022 SHALL hold upd_valid, upd_stat and upd_inc stable while upd_valid=1 and upd_ready=0.
REQ-023 SHALL, when a source fires while its pending flag is already set and is not being cleared that cycle, keep the flag set and increment drop_cnt, saturating at 255.
REQ-024 SHALL, on a pending flag being cleared and re-set in the same cycle, leave the flag set with no drop counted.
REQ-025 SHALL, while dead=1, freeze all three ms counters, ignore feed edges, clear all pending flags, and force IDLE (upd_valid=0) on the next cycle, including mid-ISSUE.
REQ-026 SHALL offer a maximum of one update per two cycles (latency pending->upd_valid = 1 cycle).

Reset
REQ-027 SHALL, on rst=0 at a clk edge, clear the prescaler, all ms counters, pending flags, drop_cnt, edge-detect register and round-robin pointer, and enter IDLE.
REQ-028 SHALL drive upd_valid=0, upd_stat=0, upd_inc=0, drop_cnt=0 during and after reset until the first event.
REQ-029 SHALL abandon an in-flight update on reset without a handshake.

Structure
REQ-030 SHALL place the stat codes (ENERGY=0, HUNGER=1, ENTERT=2) and the FSM state encoding in the shared pet package used by the pet FSM.
REQ-031 SHALL instantiate one sub-module, ms_period_timer (prescaled counter with wrap pulse), three times.

Verification (COUNT_MAX=4, ENER_MS=3, FEED_MS=2, ENTERT_MS=5)
REQ-032 SHALL test: upd_ready=1 always, idle pet -> hunger dec at ms 2, 4; energy dec at ms 3; entertainment dec at ms 5; drop_cnt=0.
REQ-033 SHALL test: sleeping=1, playing=1 -> energy and entertainment updates carry upd_inc=1; hunger carries upd_inc=0.
REQ-034 SHALL test: feed_req high for 10 cycles, coinciding with a hunger timer event -> feed (stat 1, inc) granted first, hunger dec next; exactly one feed update.
REQ-035 SHALL test: upd_ready=0 for 20 ms -> outputs stable, drop_cnt increments for each repeat firing, and the values drain in round-robin order once ready=1.
REQ-036 SHALL test: dead=1 asserted while in ISSUE -> upd_valid=0 next cycle, no further updates; dead=0 resumes counting from the frozen values.
REQ-037 SHALL test: rst=0 for one cycle mid-ISSUE -> all outputs 0 next cycle; first event reoccurs a full period later.
